// File: rtl/gpio_pin_bank_bfm_if.sv
// Command/read bus of the GPIO pin-bank BFM: bank-oriented drive, watch and
// event requests from test software, plus a combinational sample read port.
interface gpio_pin_bank_bfm_if;
    // Handshake: a request transfers on the rising clock edge where
    // req_valid && req_ready. The master holds req_op/req_bank/req_value/
    // req_mask stable while req_valid is high. A WAIT_EVENT request with
    // nothing pending is held off (req_ready low) and may be withdrawn.
    // rsp_data is valid in the cycle the WAIT_EVENT transfers.
    // req_err flags a bank outside the API range; such requests are accepted
    // and ignored.
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [7:0]  req_bank;
    logic [31:0] req_value;
    logic [31:0] req_mask;
    logic        req_err;
    logic [31:0] rsp_data;
    logic [7:0]  rd_bank;
    logic [31:0] rd_data;

    modport master (
        output req_valid, req_op, req_bank, req_value, req_mask, rd_bank,
        input  req_ready, req_err, rsp_data, rd_data
    );

    modport slave (
        input  req_valid, req_op, req_bank, req_value, req_mask, rd_bank,
        output req_ready, req_err, rsp_data, rd_data
    );
endinterface

// File: rtl/gpio_pin_bank_bfm.sv
// GPIO pad bank model: drives DUT inputs, resolves DUT outputs against its own
// drive and an external override, and latches change events on watched pins.
module gpio_pin_bank_bfm #(
    parameter int N_PINS  = 38,
    parameter int N_BANKS = (N_PINS + 31) / 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [N_PINS-1:0] pin_i,
    output logic [N_PINS-1:0] pin_o,
    input  logic [N_PINS-1:0] pin_oe,
    output logic [N_PINS-1:0] banks_i,
    input  logic [N_PINS-1:0] banks_o,
    input  logic [N_PINS-1:0] banks_oe,
    gpio_pin_bank_bfm_if.slave bus
);

    localparam logic [1:0] OP_SET_BANK   = 2'd0;
    localparam logic [1:0] OP_SET_WATCH  = 2'd1;
    localparam logic [1:0] OP_WAIT_EVENT = 2'd2;

    logic [N_PINS-1:0] drive_q, drive_d;
    logic [N_PINS-1:0] sample_q;
    logic [N_PINS-1:0] watch_q, watch_d;
    logic [N_PINS-1:0] evt_q, evt_d;
    logic [N_PINS-1:0] resolved;
    logic [N_PINS-1:0] pending;
    logic [N_PINS-1:0] clr;
    logic [N_PINS-1:0] wr_mask;
    logic [N_PINS-1:0] wr_value;
    logic [N_PINS-1:0] bank_all;
    logic [N_PINS-1:0] ack_bits;
    logic [31:0]       pend_slice;
    logic              bank_valid;
    logic              fire;

    // Spreads a 32-bit bank word onto the pins of bank b; pins past N_PINS drop out.
    function automatic logic [N_PINS-1:0] place32(input logic [31:0] v, input logic [7:0] b);
        place32 = '0;
        for (int k = 0; k < N_PINS; k++) begin
            if ((k / 32) == int'(b)) place32[k] = v[k % 32];
        end
    endfunction

    function automatic logic [31:0] slice32(input logic [N_PINS-1:0] v, input logic [7:0] b);
        slice32 = '0;
        for (int k = 0; k < N_PINS; k++) begin
            if ((k / 32) == int'(b)) slice32[k % 32] = v[k];
        end
    endfunction

    assign pin_o    = (banks_oe & banks_o) | (~banks_oe & drive_q);
    assign resolved = (pin_oe & pin_i) | (~pin_oe & pin_o);
    assign banks_i  = resolved;

    assign pending    = evt_q & watch_q;
    assign bank_valid = int'(bus.req_bank) < N_BANKS;
    assign pend_slice = bank_valid ? slice32(pending, bus.req_bank) : 32'h0;

    assign bus.req_err  = ~bank_valid;
    assign bus.rsp_data = pend_slice;
    assign bus.rd_data  = (int'(bus.rd_bank) < N_BANKS) ? slice32(sample_q, bus.rd_bank) : 32'h0;

    // A wait on a valid bank is held off until something is pending there.
    assign bus.req_ready = ~reset &
                           ((bus.req_op != OP_WAIT_EVENT) | ~bank_valid | (pend_slice != 32'h0));
    assign fire = bus.req_valid & bus.req_ready & bank_valid;

    always_comb begin
        wr_mask  = place32(bus.req_mask, bus.req_bank);
        wr_value = place32(bus.req_value, bus.req_bank);
        bank_all = place32(32'hFFFF_FFFF, bus.req_bank);
        ack_bits = place32(pend_slice, bus.req_bank);
        drive_d  = drive_q;
        watch_d  = watch_q;
        clr      = '0;
        if (fire) begin
            case (bus.req_op)
                OP_SET_BANK: begin
                    drive_d = (drive_q & ~wr_mask) | (wr_value & wr_mask);
                end
                OP_SET_WATCH: begin
                    watch_d = (watch_q & ~bank_all) | wr_mask;
                    clr     = wr_mask;
                end
                OP_WAIT_EVENT: begin
                    clr = ack_bits;
                end
                default: ;
            endcase
        end
        // Clears land before the OR-in so a change on the same edge survives.
        evt_d = (evt_q & ~clr) | (watch_q & (resolved ^ sample_q));
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            drive_q  <= '0;
            sample_q <= '0;
            watch_q  <= '0;
            evt_q    <= '0;
        end else begin
            drive_q  <= drive_d;
            sample_q <= resolved;
            watch_q  <= watch_d;
            evt_q    <= evt_d;
        end
    end

endmodule

// File: tb/tb_gpio_pin_bank_bfm.sv
// Self-checking bench for gpio_pin_bank_bfm: directed scenarios followed by
// randomized traffic compared against a per-pin behavioural model.
module tb_gpio_pin_bank_bfm;

    localparam int N  = 38;
    localparam int NB = (N + 31) / 32;
    localparam logic [1:0] OP_SET_BANK   = 2'd0;
    localparam logic [1:0] OP_SET_WATCH  = 2'd1;
    localparam logic [1:0] OP_WAIT_EVENT = 2'd2;

    logic         clock;
    logic         reset;
    logic [N-1:0] pin_i, pin_o, pin_oe, banks_i, banks_o, banks_oe;

    gpio_pin_bank_bfm_if bus();

    gpio_pin_bank_bfm #(.N_PINS(N)) dut (
        .clock    (clock),
        .reset    (reset),
        .pin_i    (pin_i),
        .pin_o    (pin_o),
        .pin_oe   (pin_oe),
        .banks_i  (banks_i),
        .banks_o  (banks_o),
        .banks_oe (banks_oe),
        .bus      (bus)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model: one bit per pin, updated once per rising edge.
    logic [N-1:0] m_drive, m_drive_nx, m_watch, m_watch_nx, m_evt, m_sample, m_clr;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_drive = '0; m_drive_nx = '0; m_watch = '0; m_watch_nx = '0;
        m_evt = '0; m_sample = '0; m_clr = '0;
    endtask

    function automatic logic [N-1:0] exp_pin_o();
        for (int k = 0; k < N; k++) exp_pin_o[k] = banks_oe[k] ? banks_o[k] : m_drive[k];
    endfunction

    function automatic logic [N-1:0] exp_resolved();
        logic [N-1:0] po;
        po = exp_pin_o();
        for (int k = 0; k < N; k++) exp_resolved[k] = pin_oe[k] ? pin_i[k] : po[k];
    endfunction

    function automatic logic [31:0] m_bank(input logic [N-1:0] v, input int b);
        m_bank = '0;
        for (int j = 0; j < 32; j++) if (32 * b + j < N) m_bank[j] = v[32 * b + j];
    endfunction

    function automatic logic [31:0] m_pending(input int b);
        return m_bank(m_evt & m_watch, b);
    endfunction

    function automatic logic [N-1:0] rand_pins();
        return N'({$urandom, $urandom});
    endfunction

    // Advances one rising edge and applies the spec's edge rules to the model.
    task automatic cycle();
        logic [N-1:0] res;
        res = exp_resolved();
        @(posedge clock);
        if (reset) begin
            model_clear();
        end else begin
            for (int k = 0; k < N; k++)
                m_evt[k] = (m_evt[k] & ~m_clr[k]) | (m_watch[k] & (res[k] ^ m_sample[k]));
            m_sample = res;
            m_drive  = m_drive_nx;
            m_watch  = m_watch_nx;
        end
        m_clr = '0; m_drive_nx = m_drive; m_watch_nx = m_watch;
        #1;
    endtask

    task automatic set_bank(input int b, input logic [31:0] v, input logic [31:0] m);
        if (b >= NB) begin
            $error("set_bank: bank %0d out of range", b);
            return;
        end
        bus.req_op = OP_SET_BANK; bus.req_bank = 8'(b);
        bus.req_value = v; bus.req_mask = m; bus.req_valid = 1'b1;
        for (int j = 0; j < 32; j++)
            if (32 * b + j < N && m[j]) m_drive_nx[32 * b + j] = v[j];
        #1;
        check("set_ready", {63'h0, bus.req_ready}, 64'h1);
        cycle();
        bus.req_valid = 1'b0;
    endtask

    task automatic set_watch(input int b, input logic [31:0] m);
        if (b >= NB) begin
            $error("set_watch: bank %0d out of range", b);
            return;
        end
        bus.req_op = OP_SET_WATCH; bus.req_bank = 8'(b);
        bus.req_mask = m; bus.req_valid = 1'b1;
        for (int j = 0; j < 32; j++)
            if (32 * b + j < N) begin
                m_watch_nx[32 * b + j] = m[j];
                if (m[j]) m_clr[32 * b + j] = 1'b1;
            end
        cycle();
        bus.req_valid = 1'b0;
    endtask

    task automatic get_bank(input int b, output logic [31:0] v);
        bus.rd_bank = 8'(b);
        #1;
        v = bus.rd_data;
    endtask

    task automatic wait_event(input int b, output logic [31:0] v, output bit got, input int budget);
        logic [31:0] p;
        got = 1'b0;
        v = '0;
        if (b >= NB) begin
            $error("wait_event: bank %0d out of range", b);
            return;
        end
        bus.req_op = OP_WAIT_EVENT; bus.req_bank = 8'(b); bus.req_valid = 1'b1;
        for (int i = 0; i < budget && !got; i++) begin
            #1;
            p = m_pending(b);
            check("wait_ready", {63'h0, bus.req_ready}, {63'h0, (p != 32'h0)});
            if (bus.req_ready) begin
                v = bus.rsp_data;
                got = 1'b1;
                for (int j = 0; j < 32; j++) if (32 * b + j < N && p[j]) m_clr[32 * b + j] = 1'b1;
            end
            cycle();
        end
        bus.req_valid = 1'b0;
    endtask

    initial begin
        logic [31:0] v;
        bit          got;
        logic [31:0] exp_v;
        int          b;

        reset = 1'b1;
        pin_i = '0; pin_oe = '0; banks_o = '0; banks_oe = '0;
        bus.req_valid = 1'b0; bus.req_op = OP_SET_BANK; bus.req_bank = '0;
        bus.req_value = '0; bus.req_mask = '0; bus.rd_bank = '0;
        model_clear();

        // Reset values
        #2;
        check("rst_pin_o", 64'(pin_o), 64'h0);
        check("rst_banks_i", 64'(banks_i), 64'h0);
        cycle();
        cycle();
        reset = 1'b0;
        cycle();
        get_bank(0, v); check("rst_bank0", 64'(v), 64'h0);
        get_bank(1, v); check("rst_bank1", 64'(v), 64'h0);

        // Full-bank drive with one clock latency to pin_o and another to sample
        check("drv_before", 64'(pin_o[31:0]), 64'h0);
        set_bank(0, 32'hA5A5_0F0F, 32'hFFFF_FFFF);
        check("drv_pin_o", 64'(pin_o[31:0]), 64'hA5A5_0F0F);
        get_bank(0, v); check("drv_sample_lag", 64'(v), 64'h0);
        cycle();
        get_bank(0, v); check("drv_sample", 64'(v), 64'hA5A5_0F0F);

        // Masked drive on the partial bank
        set_bank(1, 32'hFFFF_FFFF, 32'h0000_0030);
        check("mask_pin_o_hi", 64'(pin_o[37:32]), 64'h30);
        cycle();
        get_bank(1, v); check("mask_bank1", 64'(v), 64'h30);

        // DUT drives pins 20..16
        set_bank(0, 32'h0, 32'hFFFF_FFFF);
        pin_oe[20:16] = 5'h1F; pin_i[20:16] = 5'h15;
        #1;
        check("dut_banks_i", 64'(banks_i[20:16]), 64'h15);
        check("dut_pin_o", 64'(pin_o), 64'h30_0000_0000);
        cycle();
        get_bank(0, v); check("dut_bank0", 64'(v), 64'h0015_0000);

        // Override and contention on pin 3
        banks_oe[3] = 1'b1; banks_o[3] = 1'b1;
        #1;
        check("ovr_pin_o", 64'(pin_o[3]), 64'h1);
        check("ovr_banks_i", 64'(banks_i[3]), 64'h1);
        pin_oe[3] = 1'b1; pin_i[3] = 1'b0;
        #1;
        check("cont_banks_i", 64'(banks_i[3]), 64'h0);
        check("cont_pin_o", 64'(pin_o[3]), 64'h1);
        pin_oe[3] = 1'b0; banks_oe[3] = 1'b0; banks_o[3] = 1'b0;
        cycle();

        // Events on pin 8; pin 9 is unwatched
        pin_oe[9:8] = 2'b11; pin_i[9:8] = 2'b00;
        cycle();
        set_watch(0, 32'h0000_0100);
        pin_i[8] = 1'b1;
        wait_event(0, v, got, 6);
        check("evt1_got", {63'h0, got}, 64'h1);
        check("evt1_val", 64'(v), 64'h100);
        pin_i[9] = 1'b1;
        cycle(); cycle(); cycle();
        wait_event(0, v, got, 4);
        check("evt_unwatched_blocked", {63'h0, got}, 64'h0);
        pin_i[8] = 1'b0;
        wait_event(0, v, got, 6);
        check("evt2_got", {63'h0, got}, 64'h1);
        check("evt2_val", 64'(v), 64'h100);

        // Out-of-range bank via the raw bus is flagged and ignored
        bus.req_op = OP_SET_BANK; bus.req_bank = 8'd2;
        bus.req_value = 32'hFFFF_FFFF; bus.req_mask = 32'hFFFF_FFFF; bus.req_valid = 1'b1;
        #1;
        check("bad_bank_err", {63'h0, bus.req_err}, 64'h1);
        cycle();
        bus.req_valid = 1'b0;
        check("bad_bank_pin_o", 64'(pin_o), 64'(exp_pin_o()));

        // Randomized traffic against the model
        for (int it = 0; it < 300; it++) begin
            b = int'($urandom_range(0, NB - 1));
            case ($urandom_range(0, 5))
                0: set_bank(b, $urandom, $urandom);
                1: pin_oe = rand_pins();
                2: pin_i = rand_pins();
                3: begin banks_o = rand_pins(); banks_oe = rand_pins() & rand_pins(); end
                4: set_watch(b, $urandom & $urandom);
                default: cycle();
            endcase
            #1;
            check("rnd_pin_o", 64'(pin_o), 64'(exp_pin_o()));
            check("rnd_banks_i", 64'(banks_i), 64'(exp_resolved()));
            for (int bb = 0; bb < NB; bb++) begin
                get_bank(bb, v);
                check("rnd_get_bank", 64'(v), 64'(m_bank(m_sample, bb)));
            end
            for (int bb = 0; bb < NB; bb++) begin
                exp_v = m_pending(bb);
                if (exp_v != 32'h0) begin
                    wait_event(bb, v, got, 2);
                    check("rnd_wait_got", {63'h0, got}, 64'h1);
                    check("rnd_wait_val", 64'(v), 64'(exp_v));
                end
            end
            cycle();
        end

        // Asynchronous reset in the middle of a cycle
        banks_o = rand_pins(); banks_oe = rand_pins();
        #2;
        reset = 1'b1;
        model_clear();
        #1;
        check("arst_pin_o", 64'(pin_o), 64'(banks_o & banks_oe));
        get_bank(0, v); check("arst_bank0", 64'(v), 64'h0);
        cycle();
        reset = 1'b0;
        cycle();
        check("arst_after_pin_o", 64'(pin_o), 64'(exp_pin_o()));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
